// File: rtl/parity_ctrl_pkg.sv
// Shared types for the parity frame controller: FSM state encodings, requester ID
// and the round-robin grant helper.
package parity_ctrl_pkg;

    localparam int REQ_COUNT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } par_state_t;

    typedef logic req_id_t;

    // On contention the requester that was not served last wins.
    function automatic logic [REQ_COUNT-1:0] rr_grant(
        input logic [REQ_COUNT-1:0] valid,
        input req_id_t              last_grant
    );
        logic [REQ_COUNT-1:0] grant;
        grant = '0;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/parity_serial_fsm.sv
// Serial parity engine: a two-state machine toggling on every enabled 1 bit;
// clr returns it to EVEN.
module parity_serial_fsm
    import parity_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic par
);

    par_state_t state;
    par_state_t state_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EVEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = EVEN;
        end else if (en && din) begin
            state_next = (state == EVEN) ? ODD : EVEN;
        end
    end

    assign par = (state == ODD);

endmodule

// File: rtl/parity_frame_controller.sv
// Round-robin front end that feeds words LSB-first into one shared serial parity engine.
// Define PARITY_FRAME_CTRL_ODD_EN to report odd parity instead of even parity.
module parity_frame_controller
    import parity_ctrl_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REQ_COUNT-1:0] req_valid,
    output logic [REQ_COUNT-1:0] req_ready,
    input  logic [WIDTH-1:0]     req_data0,
    input  logic [WIDTH-1:0]     req_data1,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_id,
    output logic [WIDTH-1:0]     res_data,
    output logic                 res_parity,
    output logic                 ser_bit,
    output logic                 busy
);

    localparam int CNT_W = 6;

`ifdef PARITY_FRAME_CTRL_ODD_EN
    localparam logic PAR_INV = 1'b1;
`else
    localparam logic PAR_INV = 1'b0;
`endif

    ctrl_state_t          state;
    ctrl_state_t          state_next;
    req_id_t              last_grant;
    req_id_t              id_q;
    logic [WIDTH-1:0]     shreg;
    logic [WIDTH-1:0]     data_q;
    logic [CNT_W-1:0]     bit_cnt;
    logic [REQ_COUNT-1:0] grant;
    req_id_t              grant_id;
    logic                 accept;
    logic                 last_bit;
    logic                 eng_par;

    assign grant    = rr_grant(req_valid, last_grant);
    assign grant_id = grant[1];
    assign accept   = (state == IDLE) && (|grant);
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    assign req_ready = (state == IDLE && reset) ? grant : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CLR;
            CLR:     state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // data_q keeps the original word for res_data while shreg is consumed bit by bit
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            shreg      <= '0;
            data_q     <= '0;
            bit_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg      <= grant_id ? req_data1 : req_data0;
                        data_q     <= grant_id ? req_data1 : req_data0;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                    end
                end
                CLR: begin
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    parity_serial_fsm u_engine (
        .clk   (clk),
        .reset (reset),
        .clr   (state == CLR),
        .en    (state == SHIFT),
        .din   (shreg[0]),
        .par   (eng_par)
    );

    // The engine is idle in DONE, so its state is the finished parity for the whole hold.
    assign res_valid  = (state == DONE);
    assign res_parity = (state == DONE) & (eng_par ^ PAR_INV);
    assign res_id     = id_q;
    assign res_data   = data_q;
    assign ser_bit    = (state == SHIFT) & shreg[0];
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_controller.sv
// Directed bench for parity_frame_controller (WIDTH=3): arbitration, latency,
// serial bit order, DONE hold and reset abort; follows PARITY_FRAME_CTRL_ODD_EN.
module tb_parity_frame_controller;

    localparam int W = 3;

`ifdef PARITY_FRAME_CTRL_ODD_EN
    localparam logic ODD_BUILD = 1'b1;
`else
    localparam logic ODD_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_data0;
    logic [W-1:0] req_data1;
    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic [W-1:0] res_data;
    logic         res_parity;
    logic         ser_bit;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    parity_frame_controller #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_data   (res_data),
        .res_parity (res_parity),
        .ser_bit    (ser_bit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".req_ready"},  32'(req_ready),  32'd0);
        check({tag, ".res_valid"},  32'(res_valid),  32'd0);
        check({tag, ".res_id"},     32'(res_id),     32'd0);
        check({tag, ".res_data"},   32'(res_data),   32'd0);
        check({tag, ".res_parity"}, 32'(res_parity), 32'd0);
        check({tag, ".ser_bit"},    32'(ser_bit),    32'd0);
        check({tag, ".busy"},       32'(busy),       32'd0);
    endtask

    task automatic do_frame(input string tag, input logic [1:0] valid,
                            input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [1:0] exp_grant, input logic [W-1:0] exp_data,
                            input logic exp_even, input int hold, input bit keep);
        logic         exp_par;
        logic         exp_id;
        logic [W-1:0] ser_seq;
        int           n;
        exp_par = exp_even ^ ODD_BUILD;
        exp_id  = exp_grant[1];
        req_valid = valid;
        req_data0 = d0;
        req_data1 = d1;
        #1;
        check({tag, ".grant"}, 32'(req_ready), 32'(exp_grant));
        tick();
        if (!keep) req_valid = 2'b00;
        req_data0 = ~d0;
        req_data1 = ~d1;
        #1;
        check({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        ser_seq = '0;
        n = 1;
        while (!res_valid && n < 40) begin
            if (n >= 2 && n <= W + 1) ser_seq[n-2] = ser_bit;
            tick();
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(W + 2));
        check({tag, ".ser_seq"}, 32'(ser_seq), 32'(exp_data));
        check({tag, ".parity"}, 32'(res_parity), 32'(exp_par));
        check({tag, ".id"}, 32'(res_id), 32'(exp_id));
        check({tag, ".data"}, 32'(res_data), 32'(exp_data));
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, ".hold_valid"}, 32'(res_valid), 32'd1);
            check({tag, ".hold_parity"}, 32'(res_parity), 32'(exp_par));
            check({tag, ".hold_data"}, 32'(res_data), 32'(exp_data));
            check({tag, ".hold_id"}, 32'(res_id), 32'(exp_id));
            check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
            check({tag, ".hold_busy"}, 32'(busy), 32'd1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, ".release_valid"}, 32'(res_valid), 32'd0);
        check({tag, ".release_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen;
        reset     = 1'b0;
        req_valid = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        res_ready = 1'b0;
        tick();
        tick();
        check_idle("rst");
        req_valid = 2'b11;
        #1;
        check("rst.ready_masked", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        reset = 1'b1;
        tick();
        check_idle("post_rst");

        do_frame("single0", 2'b01, 3'b011, 3'b000, 2'b01, 3'b011, 1'b0, 0, 1'b0);
        do_frame("single1", 2'b10, 3'b000, 3'b001, 2'b10, 3'b001, 1'b1, 0, 1'b0);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        do_frame("rr0", 2'b11, 3'b111, 3'b000, 2'b01, 3'b111, 1'b1, 0, 1'b1);
        do_frame("rr1", 2'b11, 3'b111, 3'b000, 2'b10, 3'b000, 1'b0, 0, 1'b1);
        do_frame("rr2", 2'b11, 3'b111, 3'b000, 2'b01, 3'b111, 1'b1, 4, 1'b1);
        do_frame("rr3", 2'b11, 3'b111, 3'b000, 2'b10, 3'b000, 1'b0, 0, 1'b0);

        req_valid = 2'b01;
        req_data0 = 3'b111;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.res_valid", 32'(res_valid), 32'd0);
        check("abort.ser_bit", 32'(ser_bit), 32'd0);
        check("abort.res_data", 32'(res_data), 32'd0);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen |= res_valid;
        end
        check("abort.no_result", 32'(seen), 32'd0);
        do_frame("post_abort", 2'b10, 3'b000, 3'b001, 2'b10, 3'b001, 1'b1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_frame_controller.md
# parity_frame_controller

Round-robin scheduler and sequencer that shares one serial parity engine between two requesters. Each requester hands over a parallel WIDTH-bit word. The controller clears the engine, shifts the word in LSB-first (one bit per clock), captures the resulting parity bit and returns it with the requester ID. It sits between the parallel producers and the serial parity generator FSM, and owns that engine's clear and data sequencing.

## Interface
- WIDTH, default 3: bits per frame; legal range 1..32.
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-low reset.
- req_valid, input, 2: bit i set means requester i offers a word.
- req_ready, output, 2: bit i set means requester i is granted this cycle (one-hot or zero).
- req_data0, input, WIDTH: word from requester 0.
- req_data1, input, WIDTH: word from requester 1.
- res_valid, output, 1: result available.
- res_ready, input, 1: consumer accepts the result.
- res_id, output, 1: requester that owns the result.
- res_data, output, WIDTH: the word that was processed.
- res_parity, output, 1: computed parity bit.
- ser_bit, output, 1: bit currently driven into the engine (debug/observe).
- busy, output, 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: grant and accept a word.
  - CLR: clear the engine.
  - SHIFT: shift WIDTH bits, counted by bit_cnt.
  - DONE: hold the result.
- Arbitration:
  - In IDLE, if only one requester is valid, grant it.
  - If both are valid, grant the one not in last_grant.
  - last_grant resets to 1, so requester 0 wins the first contention.
- req_ready is combinational from IDLE and the grant. It is 0 outside IDLE and while reset is low.
- Transfer occurs when req_valid[i] and req_ready[i] are both high. Data and ID are latched into the shift register, last_grant updates, and the state moves to CLR.
- CLR: assert the engine clear for one cycle, load bit_cnt=0, then go to SHIFT.
- SHIFT:
  - Enable the engine with ser_bit = shreg[0], shift shreg right, increment bit_cnt.
  - When bit_cnt==WIDTH-1, go to DONE.
- DONE:
  - res_valid=1; res_parity, res_id and res_data are stable.
  - On res_valid&res_ready, go to IDLE.
  - No new request is accepted in the same cycle.
- Parity is even parity: the XOR of all WIDTH bits.
- Requester valid/data changes after acceptance have no effect on the frame in progress.
- Reset low in any state, including mid-SHIFT or DONE:
  - Next edge goes to IDLE, the frame is discarded, the engine is cleared and last_grant=1.
  - No partial result is emitted.
- Reset value of every output:
  - req_ready=0, res_valid=0, res_id=0, res_data=0, res_parity=0, ser_bit=0, busy=0.

## Timing
- Accept edge is cycle 0, CLR is cycle 1 and SHIFT is cycles 2..WIDTH+1.
- res_valid rises in cycle WIDTH+2; for WIDTH=3 that is 5 cycles after acceptance.
- Minimum frame period is WIDTH+3 cycles: DONE with res_ready held high takes 1 cycle, then 1 cycle back in IDLE.
- res_ready low holds DONE indefinitely with all result outputs stable.
- A simultaneous arrival of a second requester during a frame waits; it is served on the next IDLE according to the round-robin rule.

## Configuration
- Macro PARITY_FRAME_CTRL_ODD_EN.
- Defined: res_parity is the odd-parity bit, i.e. the inverted XOR of the word; the engine's final state is inverted on capture.
- Undefined: even parity as described above.
- Handshake and timing are identical in both builds.

## Structure
- Shared package parity_ctrl_pkg contains:
  - the state enum (IDLE, CLR, SHIFT, DONE);
  - the requester ID type;
  - a constant for the requester count (2).
- Sub-module parity_serial_fsm, the clocked serial engine:
  - inputs clk, reset, clr, en, din; output par.
  - Two states, EVEN and ODD; it toggles on en&din, and clr forces EVEN.
- The controller instantiates one engine.

## Test plan
- Single request, WIDTH=3, req_data0=3'b011 → req_ready[0] for one cycle; res_valid 5 cycles later; res_parity=0, res_id=0, res_data=3'b011.
- Single request req_data1=3'b001 → res_parity=1 and res_id=1. Also check ser_bit sequence 1,0,0 during SHIFT.
- Both requesters valid from reset, data 3'b111 and 3'b000 → requester 0 served first (parity 1), then requester 1 (parity 0); alternation continues while both stay valid.
- Hold res_ready=0 for 4 cycles in DONE → outputs stable, req_ready stays 0, busy=1; release → IDLE next cycle.
- Assert reset low in the second SHIFT cycle → next cycle busy=0, res_valid=0, with no result. A new 3'b001 frame then yields parity 1, showing the engine was cleared.
- Build with PARITY_FRAME_CTRL_ODD_EN: 3'b000 → res_parity=1; 3'b011 → res_parity=1.
